// File: rtl/round_timer_if.sv
// Round sequencer bus: game-logic requests in, HUD digits and round status out.
interface round_timer_if;
    logic       start;
    logic       pause_req;
    logic       ko;
    logic [2:0] state;
    logic [1:0] intro_count;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       frame_tick;
    logic       sec_tick;
    logic       round_over;
    logic       timeout;

    modport master (
        output start, pause_req, ko,
        input  state, intro_count, secs_tens, secs_ones,
        input  frame_tick, sec_tick, round_over, timeout
    );

    modport slave (
        input  start, pause_req, ko,
        output state, intro_count, secs_tens, secs_ones,
        output frame_tick, sec_tick, round_over, timeout
    );
endinterface

// File: rtl/round_timer_ctrl.sv
// Fighting-game round sequencer: prescaled frame/second enables drive an
// IDLE -> INTRO -> FIGHT (<-> PAUSED) -> OVER flow with a BCD countdown.
module round_timer_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int FRAME_HZ      = 60,
    parameter int ROUND_SECONDS = 99,
    parameter int INTRO_SECONDS = 3
) (
    input  logic         clk_in,
    input  logic         rst,
    round_timer_if.slave bus
);
    localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
    localparam int DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FRM_W     = (FRAME_HZ > 1) ? $clog2(FRAME_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST    = FRM_W'(FRAME_HZ - 1);
    localparam logic [3:0]       RELOAD_TENS = 4'(ROUND_SECONDS / 10);
    localparam logic [3:0]       RELOAD_ONES = 4'(ROUND_SECONDS % 10);
    localparam logic [1:0]       RELOAD_INTRO = 2'(INTRO_SECONDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INTRO  = 3'd1,
        ST_FIGHT  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic [1:0]       intro_q, intro_d;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic             timeout_q, timeout_d;
    logic             round_over_q, round_over_d;
    logic             frame_tick_q, sec_tick_q;
    logic             frame_ev_s, sec_ev_s, final_s, active_s;

    assign frame_ev_s = (div_q == DIV_LAST);
    assign div_d      = frame_ev_s ? '0 : div_q + DIV_W'(1);
    assign active_s   = (state_q == ST_INTRO) || (state_q == ST_FIGHT);
    assign sec_ev_s   = frame_ev_s && active_s && (frm_q == FRM_LAST);
    assign final_s    = sec_ev_s && (tens_q == 4'd0) && (ones_q == 4'd1);

    // Free-running prescaler; frame_tick is the registered wrap event.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            frame_tick_q <= frame_ev_s;
        end
    end

    // State and round datapath registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frm_q        <= '0;
            intro_q      <= 2'd0;
            tens_q       <= RELOAD_TENS;
            ones_q       <= RELOAD_ONES;
            timeout_q    <= 1'b0;
            round_over_q <= 1'b0;
            sec_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frm_q        <= frm_d;
            intro_q      <= intro_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            timeout_q    <= timeout_d;
            round_over_q <= round_over_d;
            sec_tick_q   <= sec_ev_s;
        end
    end

    // Next-state decision; in FIGHT ko beats the final second, which beats pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) state_d = ST_INTRO;
                else           state_d = state_q;
            end
            ST_INTRO: begin
                if (sec_ev_s && (intro_q == 2'd1)) state_d = ST_FIGHT;
                else                               state_d = state_q;
            end
            ST_FIGHT: begin
                if (bus.ko)             state_d = ST_OVER;
                else if (final_s)       state_d = ST_OVER;
                else if (bus.pause_req) state_d = ST_PAUSED;
                else                    state_d = state_q;
            end
            ST_PAUSED: begin
                if (bus.ko)             state_d = ST_OVER;
                else if (bus.pause_req) state_d = ST_FIGHT;
                else                    state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, BCD countdown and status outputs.
    always_comb begin
        intro_d      = intro_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        timeout_d    = timeout_q;
        round_over_d = (state_d == ST_OVER) && (state_q != ST_OVER);

        if (active_s && frame_ev_s) frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
        else if (state_q == ST_PAUSED || active_s) frm_d = frm_q;
        else frm_d = '0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    intro_d   = RELOAD_INTRO;
                    tens_d    = RELOAD_TENS;
                    ones_d    = RELOAD_ONES;
                    timeout_d = 1'b0;
                end else begin
                    intro_d = intro_q;
                end
            end
            ST_INTRO: begin
                if (sec_ev_s) intro_d = intro_q - 2'd1;
                else          intro_d = intro_q;
            end
            ST_FIGHT: begin
                // A KO freezes the digits even when it lands on the final second.
                if (bus.ko) begin
                    timeout_d = 1'b0;
                end else if (sec_ev_s) begin
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                    timeout_d = final_s;
                end else begin
                    timeout_d = timeout_q;
                end
            end
            default: intro_d = intro_q;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.intro_count = intro_q;
    assign bus.secs_tens   = tens_q;
    assign bus.secs_ones   = ones_q;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.sec_tick    = sec_tick_q;
    assign bus.round_over  = round_over_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed round scenarios plus random pulses, every cycle compared against a
// seconds/frames reference model of the round rules.
module tb_round_timer_ctrl;
    localparam int CLK_HZ   = 100;
    localparam int FRAME_HZ = 10;
    localparam int ROUND_S  = 3;
    localparam int INTRO_S  = 2;
    localparam int DIV      = CLK_HZ / FRAME_HZ;
    localparam logic [16:0] RST_VEC = {3'd0, 2'd0, 4'd0, 4'd3, 4'b0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    round_timer_if bus ();

    round_timer_ctrl #(
        .CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ),
        .ROUND_SECONDS(ROUND_S), .INTRO_SECONDS(INTRO_S)
    ) dut (
        .clk_in(clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: cycles since reset, frames into the current second,
    // whole seconds remaining; states 0..4 as listed for the state port.
    int m_cyc, m_frames, m_st, m_intro, m_secs;
    bit m_to, m_ro, m_sec, m_ft;

    function automatic void model_reset();
        m_cyc = 0; m_frames = 0; m_st = 0; m_intro = 0; m_secs = ROUND_S;
        m_to = 1'b0; m_ro = 1'b0; m_sec = 1'b0; m_ft = 1'b0;
    endfunction

    function automatic void model_edge(input bit s, input bit p, input bit k);
        bit fev, sev, active;
        m_cyc++;
        active = (m_st == 1) || (m_st == 2);
        fev = (m_cyc % DIV) == 0;
        sev = fev && active && (m_frames == FRAME_HZ - 1);
        if (m_st == 0 || m_st == 4) m_frames = 0;
        else if (active && fev)     m_frames = (m_frames + 1) % FRAME_HZ;
        m_ft = fev; m_sec = sev; m_ro = 1'b0;
        case (m_st)
            0, 4: if (s) begin m_st = 1; m_intro = INTRO_S; m_secs = ROUND_S; m_to = 1'b0; end
            1: if (sev) begin m_intro--; if (m_intro == 0) m_st = 2; end
            2: begin
                if (k) begin m_st = 4; m_ro = 1'b1; end
                else if (sev) begin
                    m_secs--;
                    if (m_secs == 0) begin m_st = 4; m_to = 1'b1; m_ro = 1'b1; end
                    else if (p) m_st = 3;
                end else if (p) m_st = 3;
            end
            3: if (k) begin m_st = 4; m_ro = 1'b1; end else if (p) m_st = 2;
            default: ;
        endcase
    endfunction

    function automatic bit sec_next();
        return (((m_cyc + 1) % DIV) == 0) && (m_frames == FRAME_HZ - 1) && (m_st == 1 || m_st == 2);
    endfunction

    function automatic logic [16:0] dut_vec();
        return {bus.state, bus.intro_count, bus.secs_tens, bus.secs_ones,
                bus.frame_tick, bus.sec_tick, bus.round_over, bus.timeout};
    endfunction

    function automatic logic [16:0] model_vec();
        logic [3:0] t, o;
        t = 4'(m_secs / 10);
        o = 4'(m_secs % 10);
        return {3'(m_st), 2'(m_intro), t, o, m_ft, m_sec, m_ro, m_to};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        failures++;
        $error("FAIL %s: condition not reached within cycle budget", tag);
    endtask

    task automatic step(input bit s, input bit p, input bit k);
        bus.start = s; bus.pause_req = p; bus.ko = k;
        @(posedge clk);
        model_edge(s, p, k);
        #1;
        bus.start = 1'b0; bus.pause_req = 1'b0; bus.ko = 1'b0;
        check("cycle", dut_vec(), model_vec());
    endtask

    int nf, ns, nro, n;

    initial begin
        bus.start = 1'b0; bus.pause_req = 1'b0; bus.ko = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_hold", dut_vec(), RST_VEC);
        @(negedge clk) rst = 1'b0;

        // Idle: frame ticks every DIV clocks, no seconds.
        nf = 0; ns = 0;
        repeat (50) begin step(0, 0, 0); nf += bus.frame_tick; ns += bus.sec_tick; end
        check("idle_frame_ticks", nf, 5);
        check("idle_sec_ticks", ns, 0);

        // Full round to timeout.
        step(1, 0, 0);
        check("intro_load", {bus.state, bus.intro_count, bus.secs_tens, bus.secs_ones}, {3'd1, 2'd2, 8'h03});
        nro = 0;
        for (int i = 0; i < 800 && m_st != 4; i++) begin step(0, 0, 0); nro += bus.round_over; end
        if (m_st != 4) bound_fail("timeout_reach");
        repeat (5) begin step(0, 0, 0); nro += bus.round_over; end
        check("timeout_state", bus.state, 3'd4);
        check("timeout_flag", bus.timeout, 1'b1);
        check("timeout_bcd", {bus.secs_tens, bus.secs_ones}, 8'h00);
        check("timeout_round_over_once", nro, 1);

        // Restart and KO while 02 remains.
        step(1, 0, 0);
        check("restart_reload", {bus.state, bus.intro_count, bus.secs_tens, bus.secs_ones, bus.timeout}, {3'd1, 2'd2, 8'h03, 1'b0});
        for (int i = 0; i < 800 && !(m_st == 2 && m_secs == 2); i++) step(0, 0, 0);
        if (!(m_st == 2 && m_secs == 2)) bound_fail("ko_reach");
        repeat (30) step(0, 0, 0);
        nro = 0;
        step(0, 0, 1); nro += bus.round_over;
        repeat (5) begin step(0, 0, 0); nro += bus.round_over; end
        check("ko_state", bus.state, 3'd4);
        check("ko_timeout", bus.timeout, 1'b0);
        check("ko_bcd_hold", {bus.secs_tens, bus.secs_ones}, 8'h02);
        check("ko_round_over_once", nro, 1);

        // Pause coinciding with an ordinary second: decrement then pause.
        step(1, 0, 0);
        for (int i = 0; i < 800 && !(m_st == 2 && m_secs == 3 && sec_next()); i++) step(0, 0, 0);
        if (!(m_st == 2 && m_secs == 3 && sec_next())) bound_fail("pause_sec_reach");
        step(0, 1, 0);
        check("pause_sec_collide", {bus.state, bus.secs_tens, bus.secs_ones}, {3'd3, 8'h02});
        step(0, 1, 0);
        check("pause_resume", bus.state, 3'd2);

        // Pause 40 clks into a second, hold, resume: 60 clks to the next decrement.
        for (int i = 0; i < 200 && !(m_st == 2 && m_frames == 4 && (m_cyc % DIV) == 0); i++) step(0, 0, 0);
        if (!(m_st == 2 && m_frames == 4)) bound_fail("pause40_reach");
        step(0, 1, 0);
        repeat (498) step(0, 0, 0);
        check("paused_hold", {bus.state, bus.secs_tens, bus.secs_ones}, {3'd3, 8'h02});
        step(0, 1, 0);
        n = 0;
        while (n < 200 && bus.secs_ones == 4'd2) begin step(0, 0, 0); n++; end
        check("resume_to_decrement", n, 60);

        // start in FIGHT ignored, then ko on the final-second cycle.
        step(1, 0, 0);
        check("start_in_fight_ignored", {bus.state, bus.secs_tens, bus.secs_ones}, {3'd2, 8'h01});
        for (int i = 0; i < 200 && !(m_st == 2 && m_secs == 1 && sec_next()); i++) step(0, 0, 0);
        if (!(m_st == 2 && m_secs == 1 && sec_next())) bound_fail("final_sec_reach");
        step(0, 0, 1);
        check("ko_final_collide", {bus.state, bus.timeout, bus.secs_tens, bus.secs_ones}, {3'd4, 1'b0, 8'h01});
        step(1, 0, 0);
        check("restart_after_ko", {bus.state, bus.intro_count, bus.secs_tens, bus.secs_ones}, {3'd1, 2'd2, 8'h03});

        // Random request pulses against the model.
        repeat (3000) step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 399) == 0);

        // Async reset mid-FIGHT at 02.
        for (int i = 0; i < 3000 && !(m_st == 2 && m_secs == 2); i++) step(m_st == 0 || m_st == 4, m_st == 3, 0);
        if (!(m_st == 2 && m_secs == 2)) bound_fail("async_reach");
        repeat (20) step(0, 0, 0);
        #1 rst = 1'b1;
        #1 check("async_reset_immediate", dut_vec(), RST_VEC);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        n = 0;
        while (n < 30 && bus.frame_tick !== 1'b1) begin step(0, 0, 0); n++; end
        check("first_tick_after_reset", n, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
